// File: rtl/inst_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_prefetch_queue                                                        |
// | Sequential instruction prefetch FIFO between the instruction RAM and IF/ID |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           redirect_valid,
  input  logic [31:0]                    redirect_addr,
  output logic                           iread_ce,
  output logic [31:0]                    iram_addr,
  input  logic [31:0]                    ram_inst,
  input  logic                           irom_fin,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [31:0]                    out_inst,
  output logic [31:0]                    out_pc,
  output logic [31:0]                    out_next_pc,
  output logic [$clog2(DEPTH+1)-1:0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_drop = 2'd2;

  logic [1:0]    r_state;
  logic          r_iread_ce;
  logic [31:0]   r_iram_addr;
  logic [31:0]   r_fetch_pc;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_mem_inst [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];

  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_count_next;
  logic          w_room;
  logic [31:0]   w_pc_inc;

  assign out_valid    = (r_count != '0);
  assign w_pop        = out_valid & out_ready & ~redirect_valid;
  assign w_push       = (r_state == c_st_req) & irom_fin & ~redirect_valid;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  assign w_room       = (w_count_next < c_depth);
  assign w_pc_inc     = r_fetch_pc + 32'd4;

  // Head data is forced to zero when empty so the outputs read as zero out of reset.
  assign out_inst    = out_valid ? r_mem_inst[r_head] : 32'd0;
  assign out_pc      = out_valid ? r_mem_pc[r_head] : 32'd0;
  assign out_next_pc = out_valid ? (r_mem_pc[r_head] + 32'd4) : 32'd0;
  assign fifo_count  = r_count;
  assign iread_ce    = r_iread_ce;
  assign iram_addr   = r_iram_addr;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_tail] <= ram_inst;
      r_mem_pc[r_tail]   <= r_fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= c_st_idle;
      r_iread_ce  <= 1'b0;
      r_iram_addr <= 32'd0;
      r_fetch_pc  <= RESET_PC;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
    end else if (redirect_valid) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_fetch_pc <= redirect_addr;
      // An issued RAM access cannot be aborted; its data is discarded on arrival.
      if ((r_state != c_st_idle) && !irom_fin) begin
        r_state <= c_st_drop;
      end else begin
        r_state    <= c_st_idle;
        r_iread_ce <= 1'b0;
      end
    end else begin
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
      end
      r_count <= w_count_next;
      case (r_state)
        c_st_idle: begin
          if (w_room) begin
            r_state     <= c_st_req;
            r_iread_ce  <= 1'b1;
            r_iram_addr <= r_fetch_pc;
          end
        end
        c_st_req: begin
          if (irom_fin) begin
            r_fetch_pc <= w_pc_inc;
            if (w_room) begin
              r_iram_addr <= w_pc_inc;
            end else begin
              r_state    <= c_st_idle;
              r_iread_ce <= 1'b0;
            end
          end
        end
        c_st_drop: begin
          if (irom_fin) begin
            r_state    <= c_st_idle;
            r_iread_ce <= 1'b0;
          end
        end
        default: begin
          r_state    <= c_st_idle;
          r_iread_ce <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_inst_prefetch_queue                                                     |
// | Randomized self-checking bench against a queue-based reference model       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_inst_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          CW       = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_valid;
  logic [31:0]   redirect_addr;
  logic          iread_ce;
  logic [31:0]   iram_addr;
  logic [31:0]   ram_inst;
  logic          irom_fin;
  logic          out_ready;
  logic          out_valid;
  logic [31:0]   out_inst;
  logic [31:0]   out_pc;
  logic [31:0]   out_next_pc;
  logic [CW-1:0] fifo_count;

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .iread_ce(iread_ce), .iram_addr(iram_addr),
    .ram_inst(ram_inst), .irom_fin(irom_fin),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_inst(out_inst), .out_pc(out_pc), .out_next_pc(out_next_pc),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  // Reference model: queued words, next fetch address, outstanding-request flags
  ent_t        q[$];
  logic [31:0] m_fpc;
  logic [31:0] m_addr;
  bit          m_busy;
  bit          m_discard;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  lat      = 0;
  int  wcnt     = 0;
  bit  fin_force = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_fpc     = RESET_PC;
    m_addr    = 32'd0;
    m_busy    = 1'b0;
    m_discard = 1'b0;
  endtask

  task automatic model_update(input bit fin, input logic [31:0] rd);
    bit pop;
    pop = (q.size() != 0) && out_ready && !redirect_valid;
    if (redirect_valid) begin
      q.delete();
      m_fpc = redirect_addr;
      if (m_busy && !fin) m_discard = 1'b1;
      else begin
        m_busy    = 1'b0;
        m_discard = 1'b0;
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (m_busy && fin) begin
        if (m_discard) begin
          m_busy    = 1'b0;
          m_discard = 1'b0;
        end else begin
          q.push_back('{m_fpc, rd});
          m_fpc = m_fpc + 32'd4;
          if (q.size() < DEPTH) m_addr = m_fpc;
          else m_busy = 1'b0;
        end
      end else if (!m_busy && q.size() < DEPTH) begin
        m_busy = 1'b1;
        m_addr = m_fpc;
      end
    end
  endtask

  task automatic compare();
    chk("iread_ce", 32'(iread_ce), 32'(m_busy));
    chk("iram_addr", iram_addr, m_addr);
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    if (q.size() != 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_inst", out_inst, q[0].inst);
      chk("out_next_pc", out_next_pc, q[0].pc + 32'd4);
    end
    if (!rst) begin
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk("rst_out_next_pc", out_next_pc, 32'd0);
    end
  endtask

  // One clock: RAM model drives irom_fin/ram_inst, then model and DUT advance together.
  task automatic step();
    logic        ce_now;
    bit          fin_v;
    logic [31:0] rd;
    ce_now   = iread_ce;
    fin_v    = fin_force || (ce_now && wcnt >= lat);
    rd       = fin_v ? mem_word(iram_addr) : $urandom;
    irom_fin = fin_v;
    ram_inst = rd;
    @(posedge clk);
    if (!rst) model_reset();
    else model_update(fin_v, rd);
    if (!rst || fin_v) wcnt = 0;
    else if (ce_now) wcnt++;
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_mid_request(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (iread_ce && wcnt == 1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    rst = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'd0;
    ram_inst = 32'd0; irom_fin = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    run(3);
    rst = 1'b1;

    // Zero-wait streaming with a consumer always ready
    out_ready = 1'b1;
    run(20);

    // Backpressure fills the queue, then drains in order
    out_ready = 1'b0;
    run(12);
    chk("full_count", 32'(fifo_count), 32'(DEPTH));
    out_ready = 1'b1;
    run(12);

    // Redirect during a slow access: stale word must be dropped
    lat = 3;
    wait_mid_request("wait_drop");
    redirect_valid = 1'b1; redirect_addr = 32'h8000_1000;
    step();
    redirect_valid = 1'b0;
    run(12);

    // Redirect coincident with completion and pop while holding two entries
    lat = 0; out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_addr = 32'h8000_2000;
    step();
    redirect_valid = 1'b0;
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (q.size() == 2 && iread_ce) begin
          found = 1'b1;
          break;
        end
        step();
      end
      chk("wait_two", 32'(found), 32'd1);
    end
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h8000_3000;
    step();
    redirect_valid = 1'b0;
    run(6);

    // Reset in the middle of a request, with a late completion during reset
    lat = 3;
    wait_mid_request("wait_rst");
    rst = 1'b0;
    step();
    fin_force = 1'b1;
    step();
    fin_force = 1'b0;
    rst = 1'b1;
    lat = 0;
    run(8);

    // Address wrap past 0xFFFFFFFC
    redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    run(8);

    // Randomized phases
    for (int p = 0; p < 40; p++) begin
      lat = $urandom_range(0, 3);
      for (int c = 0; c < 50; c++) begin
        out_ready      = ($urandom_range(0, 99) < 70);
        redirect_valid = ($urandom_range(0, 99) < 4);
        case ($urandom_range(0, 3))
          0:       redirect_addr = 32'hFFFF_FFF4;
          default: redirect_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        endcase
        step();
      end
      redirect_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_prefetch_queue.md
# inst_prefetch_queue

Parametrised instruction prefetch queue between the instruction-RAM port and the IF/ID pipeline register. Fetches sequential words ahead of decode into a DEPTH-entry FIFO, so IF/ID stalls no longer stall the instruction RAM and a RAM wait no longer directly stalls decode. Accepts a redirect (branch/jump/jr target) that flushes all queued and in-flight words and restarts fetch at the new address. Replaces the single-word fetch path feeding `if_id`.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low; one clock; reset is synchronous and active-low
- redirect_valid  in  1  flush queue and restart fetch at redirect_addr
- redirect_addr  in  32  new fetch address (word aligned)
- iread_ce  out  1  instruction RAM read request, registered
- iram_addr  out  32  instruction RAM address, registered, stable while iread_ce=1
- ram_inst  in  32  read data, valid in the cycle irom_fin=1
- irom_fin  in  1  one-cycle completion pulse for the outstanding read
- out_ready  in  1  consumer accepts head (= !stall_if_id)
- out_valid  out  1  head entry valid
- out_inst  out  32  head instruction
- out_pc  out  32  head instruction address
- out_next_pc  out  32  out_pc + 4
- fifo_count  out  clog2(DEPTH+1)  occupied entries

## Operation
- State machine: IDLE (no request), REQ (request outstanding, data kept), DROP (request outstanding, data discarded).
- Registers: fetch_pc, head/tail pointers (clog2(DEPTH) bits, wrap modulo DEPTH), count.
- One outstanding request maximum; iread_ce/iram_addr held constant from issue until the cycle irom_fin=1.
- IDLE: if count_next < DEPTH and no redirect → REQ, iread_ce←1, iram_addr←fetch_pc.
- REQ, irom_fin=1, no redirect: push {fetch_pc, ram_inst} at tail; fetch_pc←fetch_pc+4 (32-bit wrap); entries after push/pop < DEPTH → stay REQ, iram_addr←fetch_pc+4 (back-to-back); else → IDLE, iread_ce←0.
- REQ, irom_fin=0: hold.
- Pop when out_valid & out_ready: head advances.
- Redirect (highest priority): count←0, head=tail=0, fetch_pc←redirect_addr; pop ignored; ram_inst never pushed that cycle.
  - In IDLE, or in REQ/DROP with irom_fin=1 same cycle → IDLE (request issued next cycle).
  - In REQ/DROP with irom_fin=0 → DROP; iread_ce/iram_addr unchanged (RAM access cannot be aborted).
- DROP, irom_fin=1: discard data → IDLE, iread_ce←0. Repeated redirect in DROP overwrites fetch_pc only.
- out_valid = (count≠0); out_inst/out_pc/out_next_pc from head entry, don't-care when out_valid=0.
- Push into full queue is impossible by construction; a pop on empty never happens.

## Timing
- Reset (rst=0 at edge): state IDLE, iread_ce=0, iram_addr=0, fetch_pc=RESET_PC, count=0, out_valid=0, fifo_count=0; out_inst/out_pc/out_next_pc=0. Reset mid-request abandons it; a late irom_fin after reset is ignored (state IDLE).
- First edge with rst=1: iread_ce=1, iram_addr=RESET_PC visible after that edge.
- Fetched word visible at out_* the cycle after its irom_fin edge (no bypass); fetch→out latency = RAM latency + 1.
- Zero-wait RAM (irom_fin same cycle as iread_ce): one word/cycle sustained while not full.
- Redirect → new-target iread_ce: next cycle (IDLE path), or cycle after the stale irom_fin (DROP path).
- Simultaneous push and pop: count unchanged.

## Test plan
- Reset release, irom_fin every cycle, out_ready=1 → iram_addr 0x80000000, 0x80000004, … consecutive; out_pc follows 1 cycle later, out_next_pc=out_pc+4.
- out_ready=0, zero-wait RAM, DEPTH=4 → exactly 4 pushes, fifo_count=4, iread_ce=0; raise out_ready → pops in order 0x80000000..0x8000000C, fetching resumes.
- 3-cycle RAM latency, redirect_valid to 0x80001000 one cycle after issue → DROP, stale word never appears, fifo_count=0, next iram_addr 0x80001000 after stale irom_fin.
- redirect coincident with irom_fin and pop, queue holding 2 → fifo_count=0, out_valid=0, next-cycle request at redirect_addr.
- rst=0 mid-request with irom_fin arriving during reset → all outputs at reset values, first post-reset address 0x80000000.
- fetch_pc 0xFFFFFFFC → next address 0x00000000.
